// File: rtl/power_seq_arb16.sv
// Power shut-off sequencer: round-robin scheduler letting one domain enter/exit PSO at a time.
// Optional handshake timeout and sticky err flags enabled by defining PSO_TIMEOUT_EN.
module power_seq_arb16 #(
  parameter int unsigned NUM_DOM        = 4,
  parameter int unsigned ENTRY_SETTLE   = 5,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 63
) (
  input  logic               pclk16,
  input  logic               nprst16,
  input  logic [NUM_DOM-1:0] sw_pso_req,
  input  logic [NUM_DOM-1:0] set_status_module,
  input  logic [NUM_DOM-1:0] clr_status_module,
  input  logic               err_clr,
  output logic [NUM_DOM-1:0] l1_module_req,
  output logic [NUM_DOM-1:0] pso_status,
  output logic               busy,
  output logic [2:0]         cur_dom,
  output logic [NUM_DOM-1:0] err
);

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_ENTER_WAIT   = 3'd1;
  localparam logic [2:0] S_ENTER_SETTLE = 3'd2;
  localparam logic [2:0] S_EXIT_WAIT    = 3'd3;
  localparam logic [2:0] S_GAP          = 3'd4;

  localparam int unsigned CMAX_A = (ENTRY_SETTLE > GAP_CYCLES) ? ENTRY_SETTLE : GAP_CYCLES;
  localparam int unsigned CMAX   = (CMAX_A > TIMEOUT_CYCLES) ? CMAX_A : TIMEOUT_CYCLES;
  localparam int unsigned CW     = $clog2(CMAX + 1) + 1;

  logic [2:0]         state_q, state_d;
  logic [2:0]         cur_q, cur_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_DOM-1:0] l1_q, l1_d;
  logic [NUM_DOM-1:0] stat_q, stat_d;

  logic [NUM_DOM-1:0] entry_pend, exit_pend, cand;
  logic [NUM_DOM-1:0] cur_oh, gnt_oh;
  logic [2:0]         grant, ptr_next;
  logic               found, set_cur, clr_cur, done;

`ifdef PSO_TIMEOUT_EN
  logic [NUM_DOM-1:0] err_q, err_d;
  logic               wait_expired;
  assign err          = err_q;
  assign wait_expired = (cnt_q + CW'(1)) >= CW'(TIMEOUT_CYCLES);
`else
  logic unused_err_clr;
  assign err            = '0;
  assign unused_err_clr = err_clr;
`endif

  assign entry_pend = sw_pso_req & ~l1_q & ~err;
  assign exit_pend  = ~sw_pso_req & l1_q & stat_q & ~err;
  assign cand       = entry_pend | exit_pend;

  // Round-robin scan starting at ptr_q, wrapping at NUM_DOM (not a power of two in general).
  always_comb begin : arb
    logic [3:0] idx;
    logic [7:0] cand8;
    cand8 = '0;
    cand8[NUM_DOM-1:0] = cand;
    idx   = '0;
    found = 1'b0;
    grant = '0;
    for (int unsigned k = 0; k < NUM_DOM; k++) begin
      idx = {1'b0, ptr_q} + 4'(k);
      if (idx >= 4'(NUM_DOM)) idx = idx - 4'(NUM_DOM);
      if (!found && cand8[idx[2:0]]) begin
        found = 1'b1;
        grant = idx[2:0];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_DOM; i++) begin
      cur_oh[i] = (cur_q == 3'(i));
      gnt_oh[i] = (grant == 3'(i));
    end
  end

  assign ptr_next = (grant == 3'(NUM_DOM - 1)) ? 3'd0 : grant + 3'd1;
  assign set_cur  = |(set_status_module & cur_oh);
  assign clr_cur  = |(clr_status_module & cur_oh);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    l1_d    = l1_q;
    stat_d  = stat_q;
    done    = 1'b0;
`ifdef PSO_TIMEOUT_EN
    err_d   = err_clr ? '0 : err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          cur_d = grant;
          ptr_d = ptr_next;
          cnt_d = '0;
          if (|(gnt_oh & entry_pend)) begin
            l1_d    = l1_q | gnt_oh;
            state_d = S_ENTER_WAIT;
          end else begin
            l1_d    = l1_q & ~gnt_oh;
            state_d = S_EXIT_WAIT;
          end
        end
      end
      S_ENTER_WAIT: begin
        if (set_cur) begin
          cnt_d   = CW'(ENTRY_SETTLE);
          state_d = S_ENTER_SETTLE;
        end
`ifdef PSO_TIMEOUT_EN
        else if (wait_expired) begin
          err_d = err_d | cur_oh;
          l1_d  = l1_q & ~cur_oh;
          done  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      S_ENTER_SETTLE: begin
        // Status asserts on the edge the counter would reach zero.
        if (cnt_q <= CW'(1)) begin
          stat_d = stat_q | cur_oh;
          done   = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_EXIT_WAIT: begin
        if (clr_cur) begin
          stat_d = stat_q & ~cur_oh;
          done   = 1'b1;
        end
`ifdef PSO_TIMEOUT_EN
        else if (wait_expired) begin
          err_d = err_d | cur_oh;
          done  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      S_GAP: begin
        if (cnt_q <= CW'(1)) begin
          state_d = S_IDLE;
          cur_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cur_d   = '0;
      end
    endcase
    if (done) begin
      if (GAP_CYCLES == 0) begin
        state_d = S_IDLE;
        cur_d   = '0;
      end else begin
        state_d = S_GAP;
        cnt_d   = CW'(GAP_CYCLES);
      end
    end
  end

  always_ff @(posedge pclk16 or negedge nprst16) begin
    if (!nprst16) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      l1_q    <= '0;
      stat_q  <= '0;
`ifdef PSO_TIMEOUT_EN
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      l1_q    <= l1_d;
      stat_q  <= stat_d;
`ifdef PSO_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign l1_module_req = l1_q;
  assign pso_status    = stat_q;
  assign busy          = (state_q != S_IDLE);
  assign cur_dom       = cur_q;

endmodule
